mod10_cmd_sched: RTL and testbench
==================================

// Module: mod10_cmd_sched
// PURPOSE
//  Command scheduler in front of the mod-10 up/down counter. Takes LOAD/UP/DOWN/CLEAR
//  commands from NREQ requesters and grants them round-robin, one at a time. Drives the
//  counter's rst/mode/load/data_in pins and returns one response per command: final count,
//  requester id and an error flag. It also keeps a shadow count and checks the counter.
// PARAMETERS
//  NREQ   2  number of requesters (>=2)
//  STEPW  8  width of the step count for UP/DOWN
// PORTS
//  clk          in   1          clock; all logic on posedge
//  rst          in   1          synchronous, active-high reset
//  req_valid    in   NREQ       per-requester command valid
//  req_ready    out  NREQ       per-requester accept (one-hot or zero)
//  req_op       in   NREQ*2     opcode per requester: 0 LOAD, 1 UP, 2 DOWN, 3 CLEAR
//  req_arg      in   NREQ*4     LOAD value per requester
//  req_steps    in   NREQ*STEPW UP/DOWN step count per requester
//  cnt_rst      out  1          to counter rst (sync, active-high; counter goes to 0)
//  cnt_mode     out  1          to counter mode (1 up, 0 down)
//  cnt_load     out  1          to counter load (priority over counting)
//  cnt_data_in  out  4          to counter data_in
//  cnt_data_out in   4          from counter data_out
//  rsp_valid    out  1          one-cycle response pulse; no backpressure
//  rsp_id       out  $clog2(NREQ) requester that issued the command
//  rsp_value    out  4          cnt_data_out sampled in the response cycle
//  rsp_err      out  1          illegal LOAD arg or shadow mismatch
// BEHAVIOUR
//  - Counter model: rst -> 0. Otherwise load -> data_in. Otherwise it counts every cycle:
//    up wraps 9->0, down wraps 0->9. It has no enable, so holding it means loading the
//    shadow value.
//  - FSM states: CLR, IDLE, EXEC, RESP. All cnt_* outputs are combinational from the state
//    registers.
//  - rst high: state becomes CLR. Round-robin pointer resets to 0, shadow to 0, step counter
//    to 0. An in-flight command is dropped with no response.
//  - CLR: cnt_rst=1, cnt_load=0, cnt_mode=0, cnt_data_in=0, req_ready=0, rsp_valid=0.
//    Lasts one cycle, then IDLE. It also runs for a CLEAR command (then -> RESP).
//  - IDLE: hold the counter (cnt_load=1, cnt_data_in=shadow, cnt_mode=0).
//    - req_ready is asserted only for the round-robin winner among valid requesters.
//    - Priority starts at the pointer and searches upward, wrapping. Ties resolve by that
//      order.
//    - Grant means valid & ready in cycle T. The command is latched and the pointer moves to
//      winner+1 mod NREQ.
//    - req_valid must stay high with a stable payload until accepted.
//  - Transitions after the grant:
//    - LOAD with arg<=9: EXEC for 1 cycle (cnt_load=1, data_in=arg), shadow<=arg, then RESP.
//      rsp_valid is at T+2.
//    - LOAD with arg>9: counter untouched, go straight to RESP with rsp_err=1 at T+1.
//    - UP/DOWN with steps N>0: EXEC for N cycles (cnt_load=0, cnt_mode=op==UP). Each cycle
//      the shadow moves +/-1 mod 10. Then RESP; rsp_valid at T+N+1.
//    - UP/DOWN with N=0: RESP at T+1, counter held.
//    - CLEAR: CLR (T+1), shadow<=0, then RESP at T+2.
//  - RESP: hold the counter. rsp_valid=1 for one cycle with rsp_value=cnt_data_out and
//    rsp_id=latched id. rsp_err=1 on illegal arg or cnt_data_out!=shadow. req_ready=0.
//    Then IDLE.
//  - Throughput: at most one command in flight. No new grant is made in RESP.
//  - A requester dropping req_valid before the grant is legal: no grant, no response.
//  - Step counter is STEPW bits and counts down to 1. Shadow arithmetic is mod 10 in 4 bits.
// STRUCTURE
//  - mod10_pkg holds: op_e (LOAD/UP/DOWN/CLEAR), state_e (CLR/IDLE/EXEC/RESP), MOD=10, and a
//    function for mod-10 increment/decrement.
//  - Sub-module mod10_rr_arb: parameterised round-robin arbiter. Inputs are the request vector
//    and enable; outputs are the one-hot grant and the winner index. It owns the pointer
//    register.
//  - Top holds the FSM, command latch, step counter, shadow and mismatch compare.
// TESTING
//  1. After reset, req0 LOAD arg 7 -> cnt_load=1, cnt_data_in=7 at T+1; rsp at T+2 with
//     value 7, id 0, err 0.
//  2. LOAD 7, then UP steps 5 -> cnt_mode=1 for 5 cycles; rsp value 2 (wrap 9->0), err 0.
//  3. CLEAR, then DOWN steps 1 -> cnt_rst pulse, then rsp value 0; DOWN rsp value 9, err 0.
//  4. req0 and req1 valid together in IDLE after reset -> req0 granted first, req1 next;
//     repeated contention alternates 0,1,0,1.
//  5. LOAD arg 12 -> no cnt_load pulse, rsp at T+1 with err 1; next UP 1 from previous value
//     v gives v+1.
//  6. rst raised mid UP steps 20 -> no rsp_valid; cnt_rst=1 for the first cycle after rst;
//     a following LOAD 3 works normally.
//  Bench: a reference counter model is attached to cnt_*; inject a forced data_out error
//  -> rsp_err=1.

Source files
------------

// File: rtl/mod10_pkg.sv
// Shared types and mod-10 arithmetic for the mod-10 counter command scheduler.
package mod10_pkg;

  localparam int MOD = 10;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_UP    = 2'd1,
    OP_DOWN  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_CLR  = 2'd0,
    ST_IDLE = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // One mod-10 step in 4 bits; out-of-range values fold back into 0..9.
  function automatic logic [3:0] mod10_step(input logic [3:0] v, input logic up);
    if (up)
      mod10_step = (v >= 4'(MOD - 1)) ? 4'd0 : v + 4'd1;
    else
      mod10_step = ((v == 4'd0) || (v > 4'(MOD - 1))) ? 4'(MOD - 1) : v - 4'd1;
  endfunction

endpackage

// File: rtl/mod10_rr_arb.sv
// Round-robin arbiter: search starts at the pointer, wraps upward; pointer moves past
// each granted winner.
module mod10_rr_arb #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] win_idx,
  output logic          win_any
);

  logic [IW-1:0] ptr_reg;

  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      int c;
      c = int'(ptr_reg) + i;
      if (c >= N) c = c - N;
      if (!win_any && req[c]) begin
        win_any = 1'b1;
        win_idx = IW'(c);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_gnt
      assign gnt[gi] = en && win_any && (win_idx == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      ptr_reg <= '0;
    else if (en && win_any)
      ptr_reg <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
  end

endmodule

// File: rtl/mod10_cmd_sched.sv
// Schedules LOAD/UP/DOWN/CLEAR commands onto an external mod-10 counter, one at a time,
// and checks the counter against a shadow copy when responding.
module mod10_cmd_sched
  import mod10_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int STEPW = 8,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*2-1:0]     req_op,
  input  logic [NREQ*4-1:0]     req_arg,
  input  logic [NREQ*STEPW-1:0] req_steps,
  output logic                  cnt_rst,
  output logic                  cnt_mode,
  output logic                  cnt_load,
  output logic [3:0]            cnt_data_in,
  input  logic [3:0]            cnt_data_out,
  output logic                  rsp_valid,
  output logic [IW-1:0]         rsp_id,
  output logic [3:0]            rsp_value,
  output logic                  rsp_err
);

  state_e            state_reg, state_next;
  op_e               op_reg;
  logic [3:0]        arg_reg;
  logic [IW-1:0]     id_reg;
  logic [STEPW-1:0]  step_reg;
  logic [3:0]        shadow_reg;
  logic              bad_arg_reg;
  logic              pending_reg;

  logic [1:0]        op_arr    [NREQ];
  logic [3:0]        arg_arr   [NREQ];
  logic [STEPW-1:0]  steps_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_payload
      assign op_arr[gi]    = req_op[gi*2 +: 2];
      assign arg_arr[gi]   = req_arg[gi*4 +: 4];
      assign steps_arr[gi] = req_steps[gi*STEPW +: STEPW];
    end
  endgenerate

  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic             grant;
  op_e              sel_op;
  logic [3:0]       sel_arg;
  logic [STEPW-1:0] sel_steps;

  mod10_rr_arb #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (state_reg == ST_IDLE),
    .gnt     (req_ready),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  assign grant     = |(req_valid & req_ready);
  assign sel_op    = op_e'(op_arr[win_idx]);
  assign sel_arg   = arg_arr[win_idx];
  assign sel_steps = steps_arr[win_idx];

  assign rsp_id    = id_reg;
  assign rsp_value = cnt_data_out;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_CLR;
    else     state_reg <= state_next;
  end

  // The counter has no enable, so every non-counting state reloads the shadow value.
  always_comb begin
    state_next  = state_reg;
    cnt_rst     = 1'b0;
    cnt_load    = 1'b1;
    cnt_mode    = 1'b0;
    cnt_data_in = shadow_reg;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    case (state_reg)
      ST_CLR: begin
        cnt_rst     = 1'b1;
        cnt_load    = 1'b0;
        cnt_data_in = 4'd0;
        state_next  = pending_reg ? ST_RESP : ST_IDLE;
      end
      ST_IDLE: begin
        if (grant) begin
          case (sel_op)
            OP_LOAD:  state_next = (sel_arg > 4'(MOD - 1)) ? ST_RESP : ST_EXEC;
            OP_CLEAR: state_next = ST_CLR;
            default:  state_next = (sel_steps != '0) ? ST_EXEC : ST_RESP;
          endcase
        end
      end
      ST_EXEC: begin
        if (op_reg == OP_LOAD) begin
          cnt_data_in = arg_reg;
          state_next  = ST_RESP;
        end else begin
          cnt_load = 1'b0;
          cnt_mode = (op_reg == OP_UP);
          if (step_reg <= STEPW'(1)) state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        rsp_err    = bad_arg_reg || (cnt_data_out != shadow_reg);
        state_next = ST_IDLE;
      end
      default: state_next = ST_CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg      <= OP_LOAD;
      arg_reg     <= 4'd0;
      id_reg      <= '0;
      step_reg    <= '0;
      shadow_reg  <= 4'd0;
      bad_arg_reg <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant) begin
            op_reg      <= sel_op;
            arg_reg     <= sel_arg;
            id_reg      <= win_idx;
            step_reg    <= sel_steps;
            bad_arg_reg <= (sel_op == OP_LOAD) && (sel_arg > 4'(MOD - 1));
            pending_reg <= 1'b1;
          end
        end
        ST_CLR: shadow_reg <= 4'd0;
        ST_EXEC: begin
          if (op_reg == OP_LOAD) begin
            shadow_reg <= arg_reg;
          end else begin
            shadow_reg <= mod10_step(shadow_reg, op_reg == OP_UP);
            step_reg   <= step_reg - 1'b1;
          end
        end
        ST_RESP: pending_reg <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod10_cmd_sched.sv
// Directed bench for mod10_cmd_sched with a behavioural mod-10 counter on the cnt_* pins.
module tb_mod10_cmd_sched;

  localparam logic [1:0] LD = 2'd0, UP = 2'd1, DN = 2'd2, CL = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [7:0]  req_arg;
  logic [15:0] req_steps;
  logic        cnt_rst, cnt_mode, cnt_load;
  logic [3:0]  cnt_data_in, cnt_data_out;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [3:0]  rsp_value;
  logic        rsp_err;

  logic [3:0]  cnt_q;
  logic [3:0]  err_mask;
  int          total = 0;
  int          bad = 0;
  int          rsp_cnt = 0;
  int          mode_cnt = 0;

  mod10_cmd_sched #(.NREQ(2), .STEPW(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_arg(req_arg), .req_steps(req_steps),
    .cnt_rst(cnt_rst), .cnt_mode(cnt_mode), .cnt_load(cnt_load),
    .cnt_data_in(cnt_data_in), .cnt_data_out(cnt_data_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_value(rsp_value), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_rst)       cnt_q <= 4'd0;
    else if (cnt_load) cnt_q <= cnt_data_in;
    else if (cnt_mode) cnt_q <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
    else               cnt_q <= (cnt_q == 4'd0) ? 4'd9 : cnt_q - 4'd1;
  end
  assign cnt_data_out = cnt_q ^ err_mask;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) rsp_cnt++;
    if (cnt_mode === 1'b1 && cnt_load === 1'b0 && cnt_rst === 1'b0) mode_cnt++;
  end

  // Presents a command and returns at T+1 (one cycle after the granting edge), valid dropped.
  task automatic send(input int id, input logic [1:0] op, input logic [3:0] arg,
                      input logic [7:0] steps);
    bit got = 0;
    req_op[id*2 +: 2]    = op;
    req_arg[id*4 +: 4]   = arg;
    req_steps[id*8 +: 8] = steps;
    req_valid[id]        = 1'b1;
    #1;
    for (int k = 0; k < 30 && !got; k++) begin
      if (req_ready[id] === 1'b1) got = 1;
      else begin @(negedge clk); #1; end
    end
    @(negedge clk);
    req_valid[id] = 1'b0;
    #1;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL grant_timeout id=%0d: got no ready, want ready within 30 cycles", id);
    end
  endtask

  // Called at T+1; lat is the response cycle relative to the grant cycle T (-1 on timeout).
  task automatic wait_rsp(output int lat, output logic [3:0] v, output logic [0:0] id,
                          output logic e);
    lat = -1; v = 'x; id = 'x; e = 'x;
    for (int k = 1; k <= 40; k++) begin
      if (rsp_valid === 1'b1) begin
        lat = k; v = rsp_value; id = rsp_id; e = rsp_err;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    req_valid = '0; req_op = '0; req_arg = '0; req_steps = '0; err_mask = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (cnt_rst !== 1'b1) begin bad++; $display("FAIL rst_cnt_rst: got %b want 1", cnt_rst); end
    rst = 1'b0;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    @(negedge clk); #1;
    total++; if (cnt_rst !== 1'b0) begin bad++; $display("FAIL idle_cnt_rst: got %b want 0", cnt_rst); end
    total++; if (cnt_load !== 1'b1 || cnt_data_in !== 4'd0) begin bad++;
      $display("FAIL idle_hold: got load=%b din=%0d want load=1 din=0", cnt_load, cnt_data_in); end
  endtask

  task automatic test_load7();
    int lat; logic [3:0] v; logic [0:0] id; logic e;
    send(0, LD, 4'd7, 8'd0);
    total++; if (cnt_load !== 1'b1 || cnt_data_in !== 4'd7 || cnt_rst !== 1'b0) begin bad++;
      $display("FAIL load7_pins: got load=%b din=%0d rst=%b want 1/7/0", cnt_load, cnt_data_in, cnt_rst); end
    wait_rsp(lat, v, id, e);
    total++; if (lat !== 2) begin bad++; $display("FAIL load7_lat: got %0d want 2", lat); end
    total++; if (v !== 4'd7) begin bad++; $display("FAIL load7_value: got %0d want 7", v); end
    total++; if (id !== 1'b0) begin bad++; $display("FAIL load7_id: got %0d want 0", id); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL load7_err: got %b want 0", e); end
    @(negedge clk); #1;
  endtask

  task automatic test_up5();
    int lat; logic [3:0] v; logic [0:0] id; logic e; int m0;
    m0 = mode_cnt;
    send(0, UP, 4'd0, 8'd5);
    total++; if (cnt_mode !== 1'b1 || cnt_load !== 1'b0) begin bad++;
      $display("FAIL up5_pins: got mode=%b load=%b want 1/0", cnt_mode, cnt_load); end
    wait_rsp(lat, v, id, e);
    total++; if (lat !== 6) begin bad++; $display("FAIL up5_lat: got %0d want 6", lat); end
    total++; if (v !== 4'd2 || e !== 1'b0) begin bad++;
      $display("FAIL up5_rsp: got value=%0d err=%b want 2/0", v, e); end
    total++; if (mode_cnt - m0 !== 5) begin bad++;
      $display("FAIL up5_mode_cycles: got %0d want 5", mode_cnt - m0); end
    @(negedge clk); #1;
  endtask

  task automatic test_clear_down();
    int lat; logic [3:0] v; logic [0:0] id; logic e;
    send(1, CL, 4'd0, 8'd0);
    total++; if (cnt_rst !== 1'b1) begin bad++; $display("FAIL clear_rst_pulse: got %b want 1", cnt_rst); end
    wait_rsp(lat, v, id, e);
    total++; if (lat !== 2) begin bad++; $display("FAIL clear_lat: got %0d want 2", lat); end
    total++; if (v !== 4'd0 || id !== 1'b1 || e !== 1'b0) begin bad++;
      $display("FAIL clear_rsp: got value=%0d id=%0d err=%b want 0/1/0", v, id, e); end
    @(negedge clk); #1;
    send(1, DN, 4'd0, 8'd1);
    total++; if (cnt_mode !== 1'b0 || cnt_load !== 1'b0) begin bad++;
      $display("FAIL down1_pins: got mode=%b load=%b want 0/0", cnt_mode, cnt_load); end
    wait_rsp(lat, v, id, e);
    total++; if (lat !== 2) begin bad++; $display("FAIL down1_lat: got %0d want 2", lat); end
    total++; if (v !== 4'd9 || e !== 1'b0) begin bad++;
      $display("FAIL down1_rsp: got value=%0d err=%b want 9/0", v, e); end
    @(negedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int g[4]; int n = 0; bit onehot_ok = 1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    req_op = {UP, UP}; req_arg = '0; req_steps = '0;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 60 && n < 4; k++) begin
      if (req_ready !== 2'b00) begin
        if (req_ready !== 2'b01 && req_ready !== 2'b10) onehot_ok = 0;
        g[n] = (req_ready === 2'b10) ? 1 : 0;
        n++;
      end
      @(negedge clk); #1;
    end
    req_valid = 2'b00;
    total++; if (!onehot_ok) begin bad++; $display("FAIL rr_onehot: got non-one-hot ready, want one-hot"); end
    total++; if (n !== 4) begin bad++; $display("FAIL rr_count: got %0d grants want 4", n); end
    for (int k = 0; k < n; k++) begin
      total++; if (g[k] !== (k % 2)) begin bad++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", k, g[k], k % 2); end
    end
    repeat (3) @(negedge clk); #1;
  endtask

  task automatic test_illegal_load();
    int lat; logic [3:0] v; logic [0:0] id; logic e;
    send(0, LD, 4'd4, 8'd0);
    wait_rsp(lat, v, id, e);
    @(negedge clk); #1;
    send(1, LD, 4'd12, 8'd0);
    total++; if (cnt_data_in !== 4'd4 || cnt_rst !== 1'b0) begin bad++;
      $display("FAIL bad_load_pins: got din=%0d rst=%b want 4/0", cnt_data_in, cnt_rst); end
    wait_rsp(lat, v, id, e);
    total++; if (lat !== 1) begin bad++; $display("FAIL bad_load_lat: got %0d want 1", lat); end
    total++; if (e !== 1'b1 || v !== 4'd4 || id !== 1'b1) begin bad++;
      $display("FAIL bad_load_rsp: got err=%b value=%0d id=%0d want 1/4/1", e, v, id); end
    @(negedge clk); #1;
    send(0, UP, 4'd0, 8'd1);
    wait_rsp(lat, v, id, e);
    total++; if (lat !== 2) begin bad++; $display("FAIL up1_lat: got %0d want 2", lat); end
    total++; if (v !== 4'd5 || e !== 1'b0) begin bad++;
      $display("FAIL up1_rsp: got value=%0d err=%b want 5/0", v, e); end
    @(negedge clk); #1;
  endtask

  task automatic test_rst_mid();
    int lat; logic [3:0] v; logic [0:0] id; logic e; int r0;
    r0 = rsp_cnt;
    send(0, UP, 4'd0, 8'd20);
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk); #1;
    total++; if (cnt_rst !== 1'b1) begin bad++; $display("FAIL rst_mid_cnt_rst: got %b want 1", cnt_rst); end
    rst = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    total++; if (rsp_cnt !== r0) begin bad++;
      $display("FAIL rst_mid_no_rsp: got %0d responses want 0", rsp_cnt - r0); end
    total++; if (cnt_load !== 1'b1 || cnt_data_in !== 4'd0) begin bad++;
      $display("FAIL rst_mid_hold: got load=%b din=%0d want 1/0", cnt_load, cnt_data_in); end
    send(1, LD, 4'd3, 8'd0);
    wait_rsp(lat, v, id, e);
    total++; if (lat !== 2) begin bad++; $display("FAIL load3_lat: got %0d want 2", lat); end
    total++; if (v !== 4'd3 || e !== 1'b0 || id !== 1'b1) begin bad++;
      $display("FAIL load3_rsp: got value=%0d err=%b id=%0d want 3/0/1", v, e, id); end
    @(negedge clk); #1;
  endtask

  task automatic test_mismatch();
    int lat; logic [3:0] v; logic [0:0] id; logic e;
    err_mask = 4'h1;
    send(0, UP, 4'd0, 8'd0);
    wait_rsp(lat, v, id, e);
    err_mask = 4'h0;
    total++; if (lat !== 1) begin bad++; $display("FAIL mism_lat: got %0d want 1", lat); end
    total++; if (e !== 1'b1 || v !== 4'd2) begin bad++;
      $display("FAIL mism_rsp: got err=%b value=%0d want 1/2", e, v); end
    @(negedge clk); #1;
    send(0, UP, 4'd0, 8'd0);
    wait_rsp(lat, v, id, e);
    total++; if (e !== 1'b0 || v !== 4'd3) begin bad++;
      $display("FAIL mism_clear_rsp: got err=%b value=%0d want 0/3", e, v); end
    @(negedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_load7();
    test_up5();
    test_clear_down();
    test_back_to_back();
    test_illegal_load();
    test_rst_mid();
    test_mismatch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
